// File: rtl/boot_pkg.sv
// -----------------------------------------------------------------------------
// boot_pkg
// Shared definitions for the boot-time ROM-to-RAM copy engine.
//   boot_state_t     : copy FSM states (IDLE, ISSUE, WAIT, WRITE, DONE)
//   BOOT_WORD_COUNT  : default number of words copied out of the boot ROM
//   BOOT_RAM_BASE    : default RAM word address that receives ROM word 0
// -----------------------------------------------------------------------------
package boot_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        WRITE,
        DONE
    } boot_state_t;

    localparam int BOOT_WORD_COUNT = 1024;
    localparam int BOOT_RAM_BASE   = 0;

endpackage

// File: rtl/boot_checksum.sv
// -----------------------------------------------------------------------------
// boot_checksum
// Running modulo-2^BITS sum of the words written into RAM.
//   CLK, RSTb : clock, asynchronous active-low reset
//   clear     : zero the accumulator (takes priority over en)
//   en        : add data to the accumulator this cycle
//   data      : word to add
//   zero      : high when the sum, including this cycle's word when en=1,
//               is zero; lets the caller register the final verdict on the
//               same edge that accepts the last word
// -----------------------------------------------------------------------------
module boot_checksum #(
    parameter int BITS = 32
) (
    input  logic            CLK,
    input  logic            RSTb,
    input  logic            clear,
    input  logic            en,
    input  logic [BITS-1:0] data,
    output logic            zero
);

    logic [BITS-1:0] acc;
    logic [BITS-1:0] acc_sum;

    assign acc_sum = acc + data;
    assign zero    = ((en ? acc_sum : acc) == '0);

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc_sum;
        end
    end

endmodule

// File: rtl/boot_loader.sv
// -----------------------------------------------------------------------------
// boot_loader
// Copies WORD_COUNT words from the boot ROM into main RAM, one word at a time,
// and holds the CPU in reset until the copy has finished.
//
// Build option: define BOOT_LOADER_CHECKSUM_EN to sum every copied word and
// release the CPU only when that sum is zero. Without it checksum_ok is tied
// high and cpu_resetb follows done.
//
// Ports
//   CLK, RSTb      : clock, asynchronous active-low reset
//   start          : begin the copy (looked at only while idle)
//   rom_addr       : ROM word address (registered)
//   rom_data       : ROM read data
//   rom_data_valid : rom_data matches rom_addr
//   ram_addr       : RAM write address (registered)
//   ram_wdata      : RAM write data (registered)
//   ram_we         : write request, held until ram_ready
//   ram_ready      : RAM accepts the write when ram_we && ram_ready
//   busy           : copy in progress
//   done           : copy finished, sticky until reset
//   cpu_resetb     : CPU reset, active-low
//   checksum_ok    : image checksum verdict
// -----------------------------------------------------------------------------
module boot_loader
    import boot_pkg::*;
#(
    parameter int BITS          = 32,
    parameter int ADDRESS_BITS  = 10,
    parameter int RAM_ADDR_BITS = 12,
    parameter int WORD_COUNT    = BOOT_WORD_COUNT,
    parameter int RAM_BASE      = BOOT_RAM_BASE
) (
    input  logic                     CLK,
    input  logic                     RSTb,
    input  logic                     start,
    output logic [ADDRESS_BITS-1:0]  rom_addr,
    input  logic [BITS-1:0]          rom_data,
    input  logic                     rom_data_valid,
    output logic [RAM_ADDR_BITS-1:0] ram_addr,
    output logic [BITS-1:0]          ram_wdata,
    output logic                     ram_we,
    input  logic                     ram_ready,
    output logic                     busy,
    output logic                     done,
    output logic                     cpu_resetb,
    output logic                     checksum_ok
);

    localparam int IDX_BITS = ADDRESS_BITS + 1;
    localparam logic [IDX_BITS-1:0]      LAST_INDEX = IDX_BITS'(WORD_COUNT - 1);
    localparam logic [RAM_ADDR_BITS-1:0] BASE_ADDR  = RAM_ADDR_BITS'(RAM_BASE);

    boot_state_t         state;
    boot_state_t         state_next;
    logic [IDX_BITS-1:0] index;

    logic launch;   // start seen while idle
    logic capture;  // ROM word available in WAIT
    logic accept;   // RAM took the pending write
    logic last;     // current word is the final one

    assign launch  = (state == IDLE)  && start;
    assign capture = (state == WAIT)  && rom_data_valid;
    assign accept  = (state == WRITE) && ram_ready;
    assign last    = (index == LAST_INDEX);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_next = ISSUE;
            end
            ISSUE: begin
                // Valid is not trusted here: the ROM compares against its
                // previous address and can read high before its data
                // register has loaded the new word.
                busy       = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (rom_data_valid) state_next = WRITE;
            end
            WRITE: begin
                busy = 1'b1;
                if (ram_ready) state_next = last ? DONE : ISSUE;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            index     <= '0;
            rom_addr  <= '0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_we    <= 1'b0;
        end else begin
            if (launch) begin
                index    <= '0;
                rom_addr <= '0;
            end
            if (capture) begin
                ram_wdata <= rom_data;
                // Wraps modulo 2^RAM_ADDR_BITS.
                ram_addr  <= BASE_ADDR + RAM_ADDR_BITS'(index);
                ram_we    <= 1'b1;
            end
            if (accept) begin
                ram_we <= 1'b0;
                // The final word leaves the address alone, so rom_addr never
                // wraps even when the whole ROM is copied.
                if (!last) begin
                    index    <= index + 1'b1;
                    rom_addr <= rom_addr + 1'b1;
                end
            end
        end
    end

    // ----------------------------------------------------------- checksum
`ifdef BOOT_LOADER_CHECKSUM_EN
    logic sum_zero;

    boot_checksum #(
        .BITS (BITS)
    ) u_checksum (
        .CLK   (CLK),
        .RSTb  (RSTb),
        .clear (launch),
        .en    (accept),
        .data  (ram_wdata),
        .zero  (sum_zero)
    );

    // Registered on the edge that accepts the last word, i.e. entering DONE,
    // so cpu_resetb rises together with done.
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            checksum_ok <= 1'b0;
        end else if (accept && last) begin
            checksum_ok <= sum_zero;
        end
    end

    assign cpu_resetb = done && checksum_ok;
`else
    assign checksum_ok = 1'b1;
    assign cpu_resetb  = done;
`endif

endmodule

// File: tb/tb_boot_loader.sv
// -----------------------------------------------------------------------------
// tb_boot_loader
// Three boot_loader instances, each with its own registered ROM model:
//   0: WORD_COUNT=4, RAM_BASE=0x100 (main scenarios)
//   1: ADDRESS_BITS=2, WORD_COUNT=4, RAM_BASE=0xFFE (full ROM, RAM wrap)
//   2: WORD_COUNT=1, RAM_BASE=0x7FF (single word)
// Expected writes come from a list model: word k goes to (RAM_BASE+k) mod 4096
// carrying ROM word k; the checksum verdict is the plain sum of the image.
// -----------------------------------------------------------------------------
module tb_boot_loader;

    localparam int N = 3;

`ifdef BOOT_LOADER_CHECKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    logic CLK  = 1'b0;
    logic RSTb = 1'b0;
    always #5 CLK = ~CLK;

    int wc_of   [N] = '{4, 4, 1};
    int base_of [N] = '{32'h100, 32'hFFE, 32'h7FF};

    logic        start_s     [N];
    logic        ready_s     [N];
    logic        rom_ok_s    [N];
    logic        rom_valid_s [N];
    logic [31:0] dout_s      [N];
    logic [9:0]  prev_s      [N];
    logic [9:0]  rom_addr_s  [N];
    logic [11:0] ram_addr_s  [N];
    logic [31:0] ram_wdata_s [N];
    logic        ram_we_s    [N];
    logic        busy_s      [N];
    logic        done_s      [N];
    logic        cpu_s       [N];
    logic        ck_s        [N];
    logic [31:0] mem         [N][4];

    logic [9:0] rom_addr_a;
    logic [1:0] rom_addr_b;
    logic [9:0] rom_addr_c;

    logic [45:0] wq[$];  // accepted writes: {instance, addr, data}
    int checks = 0;
    int errors = 0;

    boot_loader #(.BITS(32), .ADDRESS_BITS(10), .RAM_ADDR_BITS(12), .WORD_COUNT(4), .RAM_BASE(32'h100)) u_dut_a (
        .CLK(CLK), .RSTb(RSTb), .start(start_s[0]), .rom_addr(rom_addr_a), .rom_data(dout_s[0]),
        .rom_data_valid(rom_valid_s[0]), .ram_addr(ram_addr_s[0]), .ram_wdata(ram_wdata_s[0]),
        .ram_we(ram_we_s[0]), .ram_ready(ready_s[0]), .busy(busy_s[0]), .done(done_s[0]),
        .cpu_resetb(cpu_s[0]), .checksum_ok(ck_s[0]));

    boot_loader #(.BITS(32), .ADDRESS_BITS(2), .RAM_ADDR_BITS(12), .WORD_COUNT(4), .RAM_BASE(32'hFFE)) u_dut_b (
        .CLK(CLK), .RSTb(RSTb), .start(start_s[1]), .rom_addr(rom_addr_b), .rom_data(dout_s[1]),
        .rom_data_valid(rom_valid_s[1]), .ram_addr(ram_addr_s[1]), .ram_wdata(ram_wdata_s[1]),
        .ram_we(ram_we_s[1]), .ram_ready(ready_s[1]), .busy(busy_s[1]), .done(done_s[1]),
        .cpu_resetb(cpu_s[1]), .checksum_ok(ck_s[1]));

    boot_loader #(.BITS(32), .ADDRESS_BITS(10), .RAM_ADDR_BITS(12), .WORD_COUNT(1), .RAM_BASE(32'h7FF)) u_dut_c (
        .CLK(CLK), .RSTb(RSTb), .start(start_s[2]), .rom_addr(rom_addr_c), .rom_data(dout_s[2]),
        .rom_data_valid(rom_valid_s[2]), .ram_addr(ram_addr_s[2]), .ram_wdata(ram_wdata_s[2]),
        .ram_we(ram_we_s[2]), .ram_ready(ready_s[2]), .busy(busy_s[2]), .done(done_s[2]),
        .cpu_resetb(cpu_s[2]), .checksum_ok(ck_s[2]));

    always_comb begin
        rom_addr_s[0] = rom_addr_a;
        rom_addr_s[1] = {8'd0, rom_addr_b};
        rom_addr_s[2] = rom_addr_c;
    end

    // ROM models: one-cycle registered read; valid compares the current
    // address with the one registered last cycle (stale data after reset).
    always @(posedge CLK or negedge RSTb) begin
        for (int i = 0; i < N; i++) begin
            if (!RSTb) begin
                dout_s[i] <= 32'hDEADBEEF;
                prev_s[i] <= '0;
            end else begin
                dout_s[i] <= mem[i][rom_addr_s[i][1:0]];
                prev_s[i] <= rom_addr_s[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            rom_valid_s[i] = (prev_s[i] == rom_addr_s[i]) && rom_ok_s[i];
        end
    end

    // Write monitor.
    always @(posedge CLK) begin
        for (int i = 0; i < N; i++) begin
            if (RSTb && ram_we_s[i] && ready_s[i]) wq.push_back({2'(i), ram_addr_s[i], ram_wdata_s[i]});
        end
    end

    // ------------------------------------------------------------ model
    function automatic logic [45:0] exp_write(input int i, input int k);
        logic [11:0] a;
        a = 12'(base_of[i] + k);
        return {2'(i), a, mem[i][k]};
    endfunction

    function automatic logic exp_ok(input int i);
        logic [31:0] sum;
        sum = '0;
        for (int k = 0; k < wc_of[i]; k++) sum = sum + mem[i][k];
        return CK_EN ? (sum == 32'd0) : 1'b1;
    endfunction

    // -------------------------------------------------------- stimulus
    task automatic do_reset();
        @(negedge CLK);
        RSTb = 1'b0;
        for (int i = 0; i < N; i++) begin
            start_s[i] = 1'b0; ready_s[i] = 1'b1; rom_ok_s[i] = 1'b1;
        end
        @(negedge CLK);
        RSTb = 1'b1;
    endtask

    // Pulses start, then drives ready/valid until done (bounded). Optionally
    // holds ready low for stall_len cycles on word stall_k, and pokes start
    // while the copy is running.
    task automatic run_copy(input string tname, input int i, input int rdy_pct, input int vld_pct,
                            input int stall_k, input int stall_len, input bit poke, output int edges);
        int  cnt;
        int  left;
        bit  armed;
        wq.delete();
        cnt = 0; left = 0; armed = (stall_k >= 0); edges = -1;
        @(negedge CLK);
        start_s[i] = 1'b1;
        while (1) begin
            @(negedge CLK);
            cnt++;
            start_s[i] = poke && ($urandom_range(2) == 0);
            if (done_s[i]) begin
                edges = cnt - 1;
                break;
            end
            if (cnt > 400) begin
                checks++; errors++;
                $display("FAIL %s timeout: done still %b after %0d cycles, required 1", tname, done_s[i], cnt);
                break;
            end
            if (cnt == 1) begin
                checks++;
                if (ram_we_s[i] !== 1'b0 || busy_s[i] !== 1'b1) begin
                    errors++;
                    $display("FAIL %s issue_cycle: ram_we=%b busy=%b, required ram_we=0 busy=1", tname, ram_we_s[i], busy_s[i]);
                end
            end
            if (armed && ram_we_s[i] && ram_addr_s[i] == 12'(base_of[i] + stall_k)) begin
                armed = 1'b0;
                left  = stall_len;
            end
            if (left > 0) begin
                checks++;
                if ({ram_we_s[i], 2'(i), ram_addr_s[i], ram_wdata_s[i]} !== {1'b1, exp_write(i, stall_k)}) begin
                    errors++;
                    $display("FAIL %s stall_hold: we=%b addr=%h data=%h, required we=1 %h", tname,
                             ram_we_s[i], ram_addr_s[i], ram_wdata_s[i], exp_write(i, stall_k));
                end
                ready_s[i] = 1'b0;
                left--;
            end else begin
                ready_s[i] = ($urandom_range(99) < rdy_pct);
            end
            rom_ok_s[i] = ($urandom_range(99) < vld_pct);
        end
        start_s[i] = 1'b0; ready_s[i] = 1'b1; rom_ok_s[i] = 1'b1;
    endtask

    task automatic load_basic();
        mem[0][0] = 32'h11111111; mem[0][1] = 32'h22222222;
        mem[0][2] = 32'h33333333; mem[0][3] = 32'h44444444;
    endtask

    // ------------------------------------------------------------ tests
    task automatic test_reset();
        repeat (2) @(negedge CLK);
        for (int i = 0; i < N; i++) begin
            checks++;
            if ({rom_addr_s[i], ram_addr_s[i], ram_wdata_s[i], ram_we_s[i], busy_s[i], done_s[i], cpu_s[i], ck_s[i]}
                !== {10'd0, 12'd0, 32'd0, 4'b0000, !CK_EN}) begin
                errors++;
                $display("FAIL reset_values inst %0d: addr=%h ram_addr=%h wdata=%h we=%b busy=%b done=%b cpu=%b ck=%b",
                         i, rom_addr_s[i], ram_addr_s[i], ram_wdata_s[i], ram_we_s[i], busy_s[i], done_s[i], cpu_s[i], ck_s[i]);
            end
        end
        // Released from reset with ROM valid high on stale data: must stay idle.
        RSTb = 1'b1;
        repeat (3) @(negedge CLK);
        checks++;
        if (ram_we_s[0] !== 1'b0 || busy_s[0] !== 1'b0 || rom_valid_s[0] !== 1'b1) begin
            errors++;
            $display("FAIL idle_after_reset: we=%b busy=%b rom_valid=%b, required 0 0 1", ram_we_s[0], busy_s[0], rom_valid_s[0]);
        end
    endtask

    task automatic test_basic();
        int e;
        do_reset();
        load_basic();
        run_copy("basic", 0, 100, 100, -1, 0, 1'b0, e);
        checks++;
        if (e !== 12) begin errors++; $display("FAIL basic_latency got %0d edges, required 12", e); end
        checks++;
        if (wq.size() !== 4) begin errors++; $display("FAIL basic_count got %0d writes, required 4", wq.size()); end
        for (int k = 0; k < 4 && k < wq.size(); k++) begin
            checks++;
            if (wq[k] !== exp_write(0, k)) begin errors++; $display("FAIL basic_write%0d got %h, required %h", k, wq[k], exp_write(0, k)); end
        end
        checks++;
        if ({done_s[0], busy_s[0], ram_we_s[0], cpu_s[0], ck_s[0], rom_addr_s[0]} !== {3'b100, exp_ok(0), exp_ok(0), 10'd3}) begin
            errors++;
            $display("FAIL basic_final done=%b busy=%b we=%b cpu=%b ck=%b rom_addr=%0d, required 1 0 0 %b %b 3",
                     done_s[0], busy_s[0], ram_we_s[0], cpu_s[0], ck_s[0], rom_addr_s[0], exp_ok(0), exp_ok(0));
        end
    endtask

    task automatic test_stall();
        int e;
        do_reset();
        load_basic();
        run_copy("stall", 0, 100, 100, 2, 5, 1'b0, e);
        checks++;
        if (e !== 17) begin errors++; $display("FAIL stall_latency got %0d edges, required 17", e); end
        checks++;
        if (wq.size() !== 4) begin errors++; $display("FAIL stall_count got %0d writes, required 4", wq.size()); end
        for (int k = 0; k < 4 && k < wq.size(); k++) begin
            checks++;
            if (wq[k] !== exp_write(0, k)) begin errors++; $display("FAIL stall_write%0d got %h, required %h", k, wq[k], exp_write(0, k)); end
        end
    endtask

    task automatic test_reset_mid();
        int  e;
        bit  found;
        do_reset();
        load_basic();
        wq.delete();
        @(negedge CLK); start_s[0] = 1'b1;
        @(negedge CLK); start_s[0] = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (ram_we_s[0] && ram_addr_s[0] == 12'h101) begin found = 1'b1; break; end
            @(negedge CLK);
        end
        checks++;
        if (!found) begin errors++; $display("FAIL abort_reach_word1 got %b, required 1", found); end
        checks++;
        if (wq.size() !== 1) begin errors++; $display("FAIL abort_pre_count got %0d, required 1", wq.size()); end
        #2 RSTb = 1'b0;
        #1;
        checks++;
        if ({rom_addr_s[0], ram_addr_s[0], ram_wdata_s[0], ram_we_s[0], busy_s[0], done_s[0], cpu_s[0], ck_s[0]}
            !== {10'd0, 12'd0, 32'd0, 4'b0000, !CK_EN}) begin
            errors++;
            $display("FAIL abort_async_reset addr=%h ram_addr=%h wdata=%h we=%b busy=%b done=%b cpu=%b ck=%b",
                     rom_addr_s[0], ram_addr_s[0], ram_wdata_s[0], ram_we_s[0], busy_s[0], done_s[0], cpu_s[0], ck_s[0]);
        end
        @(negedge CLK);
        RSTb = 1'b1;
        checks++;
        if (wq.size() !== 1) begin errors++; $display("FAIL abort_dropped_write got %0d writes, required 1", wq.size()); end
        run_copy("abort_restart", 0, 100, 100, -1, 0, 1'b0, e);
        checks++;
        if (e !== 12) begin errors++; $display("FAIL abort_restart_latency got %0d, required 12", e); end
        checks++;
        if (wq.size() !== 4) begin errors++; $display("FAIL abort_restart_count got %0d, required 4", wq.size()); end
        for (int k = 0; k < 4 && k < wq.size(); k++) begin
            checks++;
            if (wq[k] !== exp_write(0, k)) begin errors++; $display("FAIL abort_write%0d got %h, required %h", k, wq[k], exp_write(0, k)); end
        end
    endtask

    task automatic test_start_ignored();
        int e;
        do_reset();
        load_basic();
        run_copy("start_ignored", 0, 100, 100, -1, 0, 1'b1, e);
        checks++;
        if (e !== 12) begin errors++; $display("FAIL busy_start_latency got %0d, required 12", e); end
        repeat (3) begin
            @(negedge CLK); start_s[0] = 1'b1;
            @(negedge CLK); start_s[0] = 1'b0;
        end
        repeat (10) @(negedge CLK);
        checks++;
        if ({wq.size() == 4, done_s[0], busy_s[0], ram_we_s[0], rom_addr_s[0]} !== {4'b1100, 10'd3}) begin
            errors++;
            $display("FAIL done_start_ignored writes=%0d done=%b busy=%b we=%b rom_addr=%0d, required 4 1 0 0 3",
                     wq.size(), done_s[0], busy_s[0], ram_we_s[0], rom_addr_s[0]);
        end
    endtask

    task automatic test_checksum();
        int e;
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            mem[0][0] = 32'h00000001; mem[0][1] = 32'h00000000; mem[0][2] = 32'h00000000;
            mem[0][3] = (pass == 0) ? 32'hFFFFFFFF : 32'hFFFFFFFE;
            run_copy("checksum", 0, 100, 100, -1, 0, 1'b0, e);
            checks++;
            if ({done_s[0], ck_s[0], cpu_s[0]} !== {1'b1, exp_ok(0), exp_ok(0)}) begin
                errors++;
                $display("FAIL checksum_pass%0d done=%b ck=%b cpu=%b, required 1 %b %b",
                         pass, done_s[0], ck_s[0], cpu_s[0], exp_ok(0), exp_ok(0));
            end
        end
    endtask

    task automatic test_wrap_and_single();
        int e;
        do_reset();
        for (int k = 0; k < 4; k++) mem[1][k] = $urandom;
        run_copy("wrap", 1, 100, 100, -1, 0, 1'b0, e);
        checks++;
        if (e !== 12) begin errors++; $display("FAIL wrap_latency got %0d, required 12", e); end
        checks++;
        if (wq.size() !== 4) begin errors++; $display("FAIL wrap_count got %0d, required 4", wq.size()); end
        for (int k = 0; k < 4 && k < wq.size(); k++) begin
            checks++;
            if (wq[k] !== exp_write(1, k)) begin errors++; $display("FAIL wrap_write%0d got %h, required %h", k, wq[k], exp_write(1, k)); end
        end
        checks++;
        if (rom_addr_s[1] !== 10'd3) begin errors++; $display("FAIL wrap_rom_addr got %0d, required 3", rom_addr_s[1]); end

        do_reset();
        mem[2][0] = $urandom;
        run_copy("single", 2, 100, 100, -1, 0, 1'b0, e);
        checks++;
        if (e !== 3) begin errors++; $display("FAIL single_latency got %0d, required 3", e); end
        checks++;
        if (wq.size() !== 1 || wq[0] !== exp_write(2, 0)) begin
            errors++;
            $display("FAIL single_write count=%0d first=%h, required 1 %h", wq.size(), (wq.size() > 0) ? wq[0] : 46'd0, exp_write(2, 0));
        end
        checks++;
        if ({done_s[2], cpu_s[2], rom_addr_s[2]} !== {1'b1, exp_ok(2), 10'd0}) begin
            errors++;
            $display("FAIL single_final done=%b cpu=%b rom_addr=%0d, required 1 %b 0", done_s[2], cpu_s[2], rom_addr_s[2], exp_ok(2));
        end
    endtask

    task automatic test_random();
        int e;
        int i;
        for (int it = 0; it < 6; it++) begin
            i = it % 2;
            for (int k = 0; k < 4; k++) mem[i][k] = $urandom;
            do_reset();
            run_copy("random", i, 60, 60, -1, 0, 1'b0, e);
            checks++;
            if (wq.size() !== wc_of[i]) begin errors++; $display("FAIL random%0d_count got %0d, required %0d", it, wq.size(), wc_of[i]); end
            for (int k = 0; k < wc_of[i] && k < wq.size(); k++) begin
                checks++;
                if (wq[k] !== exp_write(i, k)) begin errors++; $display("FAIL random%0d_write%0d got %h, required %h", it, k, wq[k], exp_write(i, k)); end
            end
            checks++;
            if ({done_s[i], busy_s[i], cpu_s[i], ck_s[i]} !== {2'b10, exp_ok(i), exp_ok(i)}) begin
                errors++;
                $display("FAIL random%0d_final done=%b busy=%b cpu=%b ck=%b, required 1 0 %b %b",
                         it, done_s[i], busy_s[i], cpu_s[i], ck_s[i], exp_ok(i), exp_ok(i));
            end
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            start_s[i] = 1'b0; ready_s[i] = 1'b1; rom_ok_s[i] = 1'b1;
            for (int k = 0; k < 4; k++) mem[i][k] = '0;
        end
        test_reset();
        test_basic();
        test_stall();
        test_reset_mid();
        test_start_ignored();
        test_checksum();
        test_wrap_and_single();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/boot_loader.md
# boot_loader

Boot-time copy engine that reads the boot ROM word by word through its address/data/data_valid port and writes each word into main RAM over a ready/valid write port. It sits between the boot ROM and the RAM arbiter. It holds the CPU in reset until the image is copied, then releases it. It is the reader/initiator for the ROM's address-in, registered-data-out interface.

## Interface
- BITS, 32, data word width; matches ROM and RAM.
- ADDRESS_BITS, 10, ROM word-address width.
- RAM_ADDR_BITS, 12, RAM word-address width.
- WORD_COUNT, 1024, words to copy; 1 ≤ WORD_COUNT ≤ 2^ADDRESS_BITS.
- RAM_BASE, 0, RAM word address receiving ROM word 0.
- CLK  in  1  system clock; all logic on rising edge.
- RSTb  in  1  reset, asynchronous, active-low.
- start  in  1  begin copy; sampled only in IDLE.
- rom_addr  out  ADDRESS_BITS  ROM word address (registered).
- rom_data  in  BITS  ROM read data.
- rom_data_valid  in  1  high when rom_data corresponds to rom_addr.
- ram_addr  out  RAM_ADDR_BITS  write address (registered).
- ram_wdata  out  BITS  write data (registered).
- ram_we  out  1  write request; held until accepted.
- ram_ready  in  1  RAM accepts the write on a cycle with ram_we && ram_ready.
- busy  out  1  copy in progress.
- done  out  1  copy complete; sticky until reset.
- cpu_resetb  out  1  CPU reset, active-low; low until done.
- checksum_ok  out  1  image checksum result (see Configuration).

## Operation
- FSM states: IDLE, ISSUE, WAIT, WRITE, DONE. A word index counter of ADDRESS_BITS+1 bits runs from 0 to WORD_COUNT-1.
- IDLE: when start=1, go to ISSUE with index=0 and rom_addr=0.
- ISSUE: lasts exactly one cycle, then go to WAIT. rom_data_valid is ignored here, because the ROM's valid compares against its previous address and can read high before the data register has loaded (for example, address 0 right after reset).
- WAIT: when rom_data_valid=1, capture rom_data into ram_wdata, set ram_addr=RAM_BASE+index truncated to RAM_ADDR_BITS, set ram_we=1, and go to WRITE. Otherwise stay in WAIT.
- WRITE: hold ram_we, ram_addr and ram_wdata stable until ram_ready=1. On acceptance, drop ram_we.
  - If index=WORD_COUNT-1, go to DONE.
  - Otherwise increment index and rom_addr, then go to ISSUE.
- DONE: done=1 and cpu_resetb=1. Terminal state; start is ignored. Only RSTb leaves it.
- start is ignored in every state except IDLE.
- busy=1 in ISSUE, WAIT and WRITE.
- Reset values:
  - State IDLE; index 0.
  - rom_addr 0, ram_addr 0, ram_wdata 0.
  - ram_we 0, busy 0, done 0.
  - cpu_resetb 0; checksum_ok 0 when the feature is compiled in.
- RSTb asserted mid-copy aborts immediately and returns all outputs to reset values. A write in flight is dropped, with no completion.

## Timing
- Against a ROM with 1-cycle registered read and ram_ready held high, each word takes 3 cycles (ISSUE, WAIT, WRITE).
- done and cpu_resetb rise 3·WORD_COUNT cycles after the cycle where start was sampled.
- Each cycle of ram_ready=0 in WRITE adds one cycle. Each extra cycle of rom_data_valid=0 in WAIT adds one cycle.
- rom_addr changes only on the edge that leaves WRITE. It is stable throughout ISSUE and WAIT.
- WORD_COUNT=1: one ISSUE/WAIT/WRITE pass, then DONE.
- At rom_addr = 2^ADDRESS_BITS - 1 the sequence terminates, because WORD_COUNT bounds it. rom_addr never wraps.
- RAM_BASE+index wraps modulo 2^RAM_ADDR_BITS.

## Configuration
- BOOT_LOADER_CHECKSUM_EN defined:
  - A BITS-wide accumulator sums every accepted word modulo 2^BITS. It is cleared on start.
  - On entering DONE, checksum_ok is registered as 1 if the sum is 0, else 0.
  - cpu_resetb is released only if checksum_ok=1. On mismatch the FSM sits in DONE with done=1 and cpu_resetb=0.
- Not defined: no accumulator; checksum_ok is constant 1 and cpu_resetb follows done.

## Structure
- Shared package boot_pkg holds:
  - the state enum (IDLE/ISSUE/WAIT/WRITE/DONE);
  - default parameter constants BOOT_WORD_COUNT, BOOT_RAM_BASE.
- One sub-module, boot_checksum: accumulator with clear, enable and data inputs and a zero-flag output. It is instantiated only under BOOT_LOADER_CHECKSUM_EN.

## Test plan
- WORD_COUNT=4, ROM words 0x11111111,0x22222222,0x33333333,0x44444444, RAM_BASE=0x100, ram_ready=1, start pulse -> writes 0x100..0x103 with those values in order; done and cpu_resetb rise 12 cycles after start was sampled.
- ram_ready low for 5 cycles on word 2 -> ram_we, ram_addr=0x102, ram_wdata=0x33333333 held stable; done delayed by exactly 5 cycles.
- Reset release with rom_addr=0, ROM prev_addr=0 (valid high) -> no RAM write before WAIT; first write carries MEM[0], not stale dout.
- RSTb asserted in WRITE of word 1 -> all outputs return to reset values asynchronously; a new start repeats the full copy from word 0.
- start pulsed while busy and again in DONE -> ignored; exactly WORD_COUNT writes observed.
- With BOOT_LOADER_CHECKSUM_EN, words 0x00000001,0xFFFFFFFF -> checksum_ok=1, cpu_resetb=1. Changing the last word to 0xFFFFFFFE -> checksum_ok=0, done=1, cpu_resetb=0.
